// File: rtl/matrix_operand_loader.sv
// rtl/matrix_operand_loader.sv - assembles streamed elements into packed A/B operands; optional framing check via MATRIX_OPERAND_LOADER_LAST_CHECK_EN
module matrix_operand_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS_A     = 2,
    parameter int COLS_A     = 2,
    parameter int COLS_B     = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [DATA_WIDTH-1:0]                        s_data,
    input  logic                                         s_valid,
    input  logic                                         s_last,
    output logic                                         s_ready,
    output logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] a,
    output logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] b,
    output logic                                         operands_valid,
    input  logic                                         operands_ack,
    output logic                                         frame_error
);

    localparam int N_A   = ROWS_A * COLS_A;
    localparam int N_B   = COLS_A * COLS_B;
    localparam int N_MAX = (N_A > N_B) ? N_A : N_B;
    localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                                         state_q, state_d;
    logic [CNT_W-1:0]                               cnt_q, cnt_d;
    logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0]  a_q, a_d;
    logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0]  b_q, b_d;
    logic                                           valid_q, valid_d;
    logic                                           err_q, err_d;
    logic                                           accept;
    logic                                           last_bad;

    // Ready is dropped both during reset and while a full pair is parked for the consumer
    assign s_ready = rst_n && (state_q != HOLD);
    assign accept  = s_valid && s_ready;

`ifdef MATRIX_OPERAND_LOADER_LAST_CHECK_EN
    // s_last must be high on exactly the final B element and nowhere else
    assign last_bad = ((state_q == LOAD_B) && (cnt_q == CNT_W'(N_B - 1))) ? !s_last : s_last;
`else
    // Frames are delimited by count only; s_last carries no meaning here
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign last_bad      = 1'b0;
`endif

    // Frame sequencing: element counting, framing errors and the hold/ack handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    if (last_bad) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(N_A - 1)) begin
                        state_d = LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (last_bad) begin
                        err_d   = 1'b1;
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(N_B - 1)) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (operands_ack) begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
        endcase
        valid_d = (state_d == HOLD);
    end

    // Element write-back: only the slot addressed by the current count changes on an accept
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        for (int k = 0; k < N_A; k++) begin
            if (accept && (state_q == LOAD_A) && (cnt_q == CNT_W'(k))) begin
                a_d[k / COLS_A][k % COLS_A] = s_data;
            end
        end
        for (int k = 0; k < N_B; k++) begin
            if (accept && (state_q == LOAD_B) && (cnt_q == CNT_W'(k))) begin
                b_d[k / COLS_B][k % COLS_B] = s_data;
            end
        end
    end

    // State, counter, operand and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign operands_valid = valid_q;
    assign frame_error    = err_q;

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Streams matrix elements in one at a time over a valid/ready interface and assembles them into the packed operand matrices `a` and `b` consumed by `matrix_multiplier`. It is the writer side of the multiplier's operand interface. It holds a complete operand pair stable, with `operands_valid` asserted, until the consumer acknowledges it. Element counting, framing checks and the operand registers are all local to this block.

## Interface
- `DATA_WIDTH`, 8: bits per matrix element.
- `ROWS_A`, 2: rows of A.
- `COLS_A`, 2: columns of A, which is also the rows of B.
- `COLS_B`, 2: columns of B.
- `clk`  in  1: rising-edge clock; the block uses only this one clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `s_data`  in  DATA_WIDTH: incoming element.
- `s_valid`  in  1: `s_data` is valid.
- `s_last`  in  1: marks the final element of a frame (the last element of B).
- `s_ready`  out  1: the loader accepts an element on this cycle.
- `a`  out  [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0]: operand A.
- `b`  out  [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0]: operand B.
- `operands_valid`  out  1: `a` and `b` hold a complete frame.
- `operands_ack`  in  1: the consumer has taken the operands.
- `frame_error`  out  1: one-cycle pulse when a malformed frame is discarded.

## Operation
- An element is accepted on a rising edge where `s_valid && s_ready`.
- Frame layout:
  - N_A = ROWS_A*COLS_A elements of A, row-major, then N_B = COLS_A*COLS_B elements of B, row-major.
  - Frame length is N_A+N_B.
  - Element k of A is written to `a[k/COLS_A][k%COLS_A]`.
  - Element k of B is written to `b[k/COLS_B][k%COLS_B]`.
- State machine, reset state LOAD_A:
  - LOAD_A: accepts A elements. After accepting element N_A-1, go to LOAD_B.
  - LOAD_B: accepts B elements. After accepting element N_B-1, go to HOLD.
  - HOLD: no elements accepted. When `operands_ack` is sampled high, go to LOAD_A.
- `s_ready` is combinational: it equals `rst_n && (state != HOLD)`.
- `operands_valid` is registered and is 1 exactly while the state is HOLD.
- `operands_ack` is ignored outside HOLD.
- Each element register updates on its own accept edge. Elements that are not written keep their previous value.
- `a` and `b` are stable throughout HOLD. After the ack, registers are overwritten progressively by the next frame.
- Element counters run from 0 to N-1. They clear on every state change and on reset.
- Reset values:
  - `a` = 0 and `b` = 0.
  - `operands_valid` = 0.
  - `frame_error` = 0.
  - `s_ready` = 0 while `rst_n` is low.
  - State = LOAD_A, counters = 0.
- Reset mid-frame discards the partial frame; the next element after release is A[0][0].

## Timing
- Per-element latency: an element accepted at edge t is visible on `a`/`b` in the cycle after t.
- Final B element accepted at edge t: `operands_valid` = 1 and `s_ready` = 0 from the cycle after t.
- Ack sampled at edge u: `operands_valid` = 0 and `s_ready` = 1 from the cycle after u.
  - At least one cycle separates the ack from the next accept.
  - Minimum frame period is N_A+N_B+1 cycles when the consumer acks immediately.
- `s_valid` may drop at any time. The counters simply stall.
- `s_data` has no constraint while `s_valid` = 0.

## Configuration
- Macro: `MATRIX_OPERAND_LOADER_LAST_CHECK_EN`.
- Defined: framing is checked.
  - `s_last` high on any accepted element other than the final B element is an error.
  - `s_last` low on the final B element is also an error.
  - On either error: pulse `frame_error` for one cycle after the accept edge, return to LOAD_A with counters cleared, and do not assert `operands_valid`.
  - `a`/`b` keep their partial contents.
- Undefined: `s_last` is ignored, `frame_error` is tied to 0, and frames are delimited purely by count.

## Test plan
- Basic load: stream 1,2,3,4,5,6,7,8 with `s_last` on 8, ack one cycle after `operands_valid` rises.
  - Required: a[0][0]=1, a[0][1]=2, a[1][0]=3, a[1][1]=4; b[0][0]=5, b[0][1]=6, b[1][0]=7, b[1][1]=8.
  - `operands_valid` rises the cycle after the 8th accept and falls the cycle after the ack.
- Gapped source: same data with `s_valid` low for 2 cycles between each element.
  - Required: identical final `a`/`b`, and no duplicate or skipped element.
- Held ack: keep `operands_ack` low for 10 cycles while holding `s_valid`=1 with data 0xFF.
  - Required: `s_ready`=0, `a`/`b` unchanged, `operands_valid`=1 throughout.
  - After the ack, the next accepted element (0xFF) lands in a[0][0].
- Early `s_last` (macro defined): assert `s_last` on the 3rd element.
  - Required: `frame_error` pulses once, with no `operands_valid`.
  - The next 8 elements 9..16 form a valid frame with a[0][0]=9 and b[1][1]=16.
- Missing `s_last` (macro defined): 8 elements with `s_last` always 0.
  - Required: `frame_error` pulses once after the 8th accept, with no `operands_valid`.
  - With the macro undefined, the same stimulus gives `operands_valid`=1 and `frame_error`=0.
- Reset mid-frame: pull `rst_n` low asynchronously after 5 accepts.
  - Required: `a`=`b`=0 and `s_ready`=0 immediately.
  - After release, stream 1..8; the result matches the basic-load values.
